// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned XLEN = 32;

  // Refill controller states
  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_DONE   = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_tagstore.sv
// Valid/tag arrays for the instruction cache: lookup compare, line write, flush-all.
module icache_tagstore
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned TW    = 26,
  localparam int unsigned IW   = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] lk_idx_i,
  input  logic [TW-1:0] lk_tag_i,
  output logic          hit_c_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [TW-1:0] wr_tag_i,
  input  logic          flush_i
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q [LINES];

  // Lookup compare against the addressed line
  assign hit_c_o = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);

  // Valid bits: only state cleared by reset; flush wins over a line write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag array, written alongside the valid bit of a filled line
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-line word-by-word refill.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic [XLEN-1:0] cpu_addr,
  output logic [XLEN-1:0] cpu_data,
  output logic            cpu_ready,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_ack
);

  localparam int unsigned OB = $clog2(WORDS);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TW = XLEN - OB - IB - 2;
  localparam int unsigned CW = OB + 1;
  localparam int unsigned AW = IB + OB;

  ic_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic [XLEN-1:0]   data_q [LINES*WORDS];

  logic [IB-1:0]     lk_idx;
  logic [OB-1:0]     lk_word;
  logic [TW-1:0]     lk_tag;
  logic [IB-1:0]     fill_idx;
  logic [TW-1:0]     fill_tag;
  logic              tag_hit;
  logic              ts_wr;
  logic              ts_flush;
  logic              unused_byte_offset;

  assign lk_word  = cpu_addr[OB+1:2];
  assign lk_idx   = cpu_addr[OB+IB+1:OB+2];
  assign lk_tag   = cpu_addr[XLEN-1:OB+IB+2];
  assign fill_idx = mem_addr_q[OB+IB+1:OB+2];
  assign fill_tag = mem_addr_q[XLEN-1:OB+IB+2];
  assign cnt_inc  = cnt_q + CW'(1);
  assign unused_byte_offset = ^cpu_addr[1:0];

  icache_tagstore #(
    .LINES (LINES),
    .TW    (TW)
  ) u_tagstore (
    .clk      (clk),
    .reset    (reset),
    .lk_idx_i (lk_idx),
    .lk_tag_i (lk_tag),
    .hit_c_o  (tag_hit),
    .wr_en_i  (ts_wr),
    .wr_idx_i (fill_idx),
    .wr_tag_i (fill_tag),
    .flush_i  (ts_flush)
  );

  // Hits are served combinationally, only while the controller is idle
  assign cpu_ready = (state_q == IC_IDLE) && cpu_req && tag_hit;
  assign cpu_data  = cpu_ready ? data_q[{lk_idx, lk_word}] : '0;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  // Next-state and refill control
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    flush_pend_d = flush_pend_q;
    ts_wr        = 1'b0;
    ts_flush     = 1'b0;
    unique case (state_q)
      IC_IDLE: begin
        ts_flush = flush;
        if (cpu_req && !tag_hit) begin
          state_d    = IC_REFILL;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {cpu_addr[XLEN-1:OB+2], (OB+2)'(0)};
        end
      end
      IC_REFILL: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (mem_ack) begin
          cnt_d      = cnt_inc;
          // Word offset wraps to zero after the last word, so the line base is restored
          mem_addr_d = {mem_addr_q[XLEN-1:OB+2], cnt_inc[OB-1:0], 2'b00};
          if (cnt_q == CW'(WORDS - 1)) begin
            mem_req_d = 1'b0;
            state_d   = IC_DONE;
          end
        end
      end
      IC_DONE: begin
        // A flush seen during the refill (or now) discards the new line
        if (flush || flush_pend_q) begin
          ts_flush = 1'b1;
        end else begin
          ts_wr = 1'b1;
        end
        flush_pend_d = 1'b0;
        cnt_d        = '0;
        state_d      = IC_IDLE;
      end
      default: begin
        state_d   = IC_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IC_IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Data array: one word written per accepted refill beat
  always_ff @(posedge clk) begin
    if ((state_q == IC_REFILL) && mem_ack) begin
      data_q[{fill_idx, cnt_q[OB-1:0]}] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic vs a line-level model.
module tb_icache;

  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned OB    = $clog2(WORDS);
  localparam int unsigned IB    = $clog2(LINES);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack = 1'b0;

  icache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_ready (cpu_ready),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Backing memory: every word holds its own address
  assign mem_data = mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder: acks each requested word after lat idle cycles
  int lat = 0;
  int wcnt = 0;
  bit noise = 1'b0;
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      mem_ack = (wcnt >= lat);
      wcnt    = mem_ack ? 0 : wcnt + 1;
    end else begin
      wcnt    = 0;
      mem_ack = noise && ($urandom_range(3) == 0);
    end
  end

  // Reference model: line valid/tag table plus the progress of one outstanding refill
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  int          m_phase;
  logic [31:0] m_base;
  int          m_got;
  bit          m_fpend;
  bit          chk_en = 1'b0;
  bit          last_ready = 1'b0;
  logic [31:0] acc_q [$];

  always @(negedge clk) begin
    int          idx;
    int          bidx;
    logic [31:0] tg;
    bit          hit;
    bit          exp_rdy;
    if (!reset) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_phase    = 0;
      m_got      = 0;
      m_fpend    = 1'b0;
      last_ready = 1'b0;
    end else if (chk_en) begin
      idx  = int'((cpu_addr >> (2 + OB)) % LINES);
      tg   = cpu_addr >> (2 + OB + IB);
      hit  = m_valid[idx] && (m_tag[idx] == tg);
      bidx = int'((m_base >> (2 + OB)) % LINES);
      if (mem_req && mem_ack) acc_q.push_back(mem_addr);
      case (m_phase)
        0: begin
          exp_rdy = cpu_req && hit;
          check("idle_ready", 32'(cpu_ready), 32'(exp_rdy));
          check("idle_data", cpu_data, exp_rdy ? (cpu_addr & ~32'h3) : 32'h0);
          check("idle_memreq", 32'(mem_req), 32'h0);
          if (flush) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
          if (cpu_req && !hit) begin
            m_phase = 1;
            m_base  = cpu_addr & ~32'(4 * WORDS - 1);
            m_got   = 0;
            m_fpend = 1'b0;
          end
        end
        1: begin
          check("fill_ready", 32'(cpu_ready), 32'h0);
          check("fill_data", cpu_data, 32'h0);
          check("fill_memreq", 32'(mem_req), 32'h1);
          check("fill_memaddr", mem_addr, m_base + 32'(4 * m_got));
          if (flush) m_fpend = 1'b1;
          if (mem_ack) begin
            m_got++;
            if (m_got == WORDS) m_phase = 2;
          end
        end
        default: begin
          check("done_ready", 32'(cpu_ready), 32'h0);
          check("done_memreq", 32'(mem_req), 32'h0);
          if (flush || m_fpend) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
          end else begin
            m_valid[bidx] = 1'b1;
            m_tag[bidx]   = m_base >> (2 + OB + IB);
          end
          m_fpend = 1'b0;
          m_phase = 0;
        end
      endcase
      last_ready = cpu_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until the current request hits (bounded)
  task automatic wait_hit(output int cyc);
    cyc = 0;
    #1;
    while (!cpu_ready && cyc < 200) begin
      @(posedge clk);
      #2;
      cyc++;
    end
  endtask

  task automatic wait_memaddr(input logic [31:0] a);
    int k = 0;
    while (mem_addr !== a && k < 100) begin
      step();
      k++;
    end
    check("wait_memaddr", mem_addr, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cpu_ready), 32'h0);
    check("rst_data", cpu_data, 32'h0);
    check("rst_memreq", 32'(mem_req), 32'h0);
    check("rst_memaddr", mem_addr, 32'h0);
    step();
    reset  = 1'b1;
    chk_en = 1'b1;

    // Cold miss, zero-wait memory
    acc_q.delete();
    cpu_req  = 1'b1;
    cpu_addr = 32'h40;
    wait_hit(cyc);
    check("cold_latency", 32'(cyc), 32'd6);
    check("cold_data", cpu_data, 32'h40);
    check("cold_nwords", 32'(acc_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("cold_seq", (i < acc_q.size()) ? acc_q[i] : 32'hDEADBEEF, 32'h40 + 32'(4 * i));

    // Hit on another word of the same line
    step();
    cpu_addr = 32'h4C;
    #1;
    check("hit_ready", 32'(cpu_ready), 32'h1);
    check("hit_data", cpu_data, 32'h4C);
    check("hit_memreq", 32'(mem_req), 32'h0);

    // Conflict on the same index
    step();
    cpu_addr = 32'h140;
    wait_hit(cyc);
    check("conf_a_latency", 32'(cyc), 32'd6);
    step();
    cpu_addr = 32'h40;
    wait_hit(cyc);
    check("conf_b_latency", 32'(cyc), 32'd6);
    step();
    cpu_addr = 32'h140;
    #1;
    check("conf_evicted", 32'(cpu_ready), 32'h0);
    wait_hit(cyc);

    // Slow memory: three idle cycles before each word
    step();
    lat      = 3;
    cpu_addr = 32'h200;
    wait_hit(cyc);
    check("slow_latency", 32'(cyc), 32'd18);
    check("slow_data", cpu_data, 32'h200);
    lat = 0;

    // Flush pulse during word 2 of the 0x80 refill
    step();
    cpu_addr = 32'h80;
    wait_memaddr(32'h88);
    flush = 1'b1;
    step();
    flush   = 1'b0;
    cpu_req = 1'b0;
    for (int k = 0; k < 20 && mem_req; k++) step();
    step();
    cpu_req  = 1'b1;
    cpu_addr = 32'h40;
    #1;
    check("flush_40_miss", 32'(cpu_ready), 32'h0);
    wait_hit(cyc);
    step();
    cpu_addr = 32'h80;
    #1;
    check("flush_80_miss", 32'(cpu_ready), 32'h0);
    wait_hit(cyc);
    check("flush_80_latency", 32'(cyc), 32'd6);

    // Reset in the middle of a refill
    step();
    cpu_addr = 32'h300;
    wait_memaddr(32'h308);
    reset = 1'b0;
    #1;
    check("rstmid_memreq", 32'(mem_req), 32'h0);
    check("rstmid_ready", 32'(cpu_ready), 32'h0);
    step();
    reset = 1'b1;
    acc_q.delete();
    wait_hit(cyc);
    check("rstmid_latency", 32'(cyc), 32'd6);
    check("rstmid_nwords", 32'(acc_q.size()), 32'd4);
    check("rstmid_first", (acc_q.size() > 0) ? acc_q[0] : 32'hDEADBEEF, 32'h300);

    // Randomized traffic: small address pool, redirects, flushes, variable latency, stray acks
    noise = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(99) < 5) lat = $urandom_range(2);
      if (last_ready || !cpu_req || $urandom_range(99) < 3) begin
        a = (32'($urandom_range(3)) << 8) | (32'($urandom_range(3)) << 4) | 32'($urandom_range(15));
        cpu_req  = ($urandom_range(9) != 0);
        cpu_addr = a;
      end
      flush = ($urandom_range(99) < 3);
    end
    step();
    flush   = 1'b0;
    cpu_req = 1'b0;
    noise   = 1'b0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
